// File: rtl/slot_spin_ctrl_if.sv
// ---------------------------------------------------------------------------
// slot_spin_if
// Bundles the signals between the slot spin controller, the player start
// input, the shared LFSR and the display/payout logic.
//
//   start        : spin request from the player (level)
//   lfsr_in      : current value of the free-running LFSR
//   lfsr_enable  : enable for the LFSR, owned by the controller
//   busy         : spin in progress
//   reel0..reel2 : captured reel symbols
//   reel_stopped : bit i set once reel i has been captured this spin
//   done         : one-cycle pulse when the last reel is captured
//   win          : all three reels equal in the last completed spin
//
// modport slave  : the controller side
// modport master : the environment side (player input, LFSR, display)
// ---------------------------------------------------------------------------
interface slot_spin_if #(
    parameter int LFSR_LENGTH = 10,
    parameter int SYM_W       = 3
);
    logic                   start;
    logic [LFSR_LENGTH-1:0] lfsr_in;
    logic                   lfsr_enable;
    logic                   busy;
    logic [SYM_W-1:0]       reel0;
    logic [SYM_W-1:0]       reel1;
    logic [SYM_W-1:0]       reel2;
    logic [2:0]             reel_stopped;
    logic                   done;
    logic                   win;

    modport slave (
        input  start, lfsr_in,
        output lfsr_enable, busy, reel0, reel1, reel2, reel_stopped, done, win
    );

    modport master (
        output start, lfsr_in,
        input  lfsr_enable, busy, reel0, reel1, reel2, reel_stopped, done, win
    );
endinterface

// File: rtl/slot_spin_ctrl.sv
// ---------------------------------------------------------------------------
// slot_spin_ctrl
// Sequences one spin of a three-reel slot machine. On an accepted start the
// controller enables the shared LFSR, waits SPIN_CYCLES, then stops reels
// 0, 1 and 2 at STOP_GAP intervals. At each stop it samples the low SYM_W bits
// of the LFSR as that reel's symbol. After the last reel it pulses done and
// reports whether all three symbols match.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : slot_spin_if.slave (start, lfsr_in in; lfsr_enable, busy,
//            reel0..2, reel_stopped, done, win out)
//
// Every output is registered except lfsr_enable, which is decoded from the
// state register so the LFSR is frozen exactly while the FSM is idle.
// ---------------------------------------------------------------------------
module slot_spin_ctrl #(
    parameter int LFSR_LENGTH = 10,
    parameter int SYM_W       = 3,
    parameter int SPIN_CYCLES = 16,
    parameter int STOP_GAP    = 8
) (
    input  logic          clk,
    input  logic          reset,
    slot_spin_if.slave    bus
);

    localparam int MAX_CNT = (SPIN_CYCLES > STOP_GAP) ? SPIN_CYCLES : STOP_GAP;
    // A single-cycle interval still needs a one-bit counter to exist.
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STOP_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        GAP1 = 2'd2,
        GAP2 = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    logic             accept_s;
    logic             cap0_s;
    logic             cap1_s;
    logic             cap2_s;
    logic [SYM_W-1:0] sym_s;

    logic             busy_r;
    logic [SYM_W-1:0] reel0_r;
    logic [SYM_W-1:0] reel1_r;
    logic [SYM_W-1:0] reel2_r;
    logic [2:0]       reel_stopped_r;
    logic             done_r;
    logic             win_r;

    assign sym_s = bus.lfsr_in[SYM_W-1:0];

    // Upper LFSR bits are not part of a symbol; fold them so they are consumed.
    generate
        if (LFSR_LENGTH > SYM_W) begin : g_unused_bits
            logic unused_lfsr_bits_s;
            assign unused_lfsr_bits_s = ^bus.lfsr_in[LFSR_LENGTH-1:SYM_W];
        end
    endgenerate

    // State and interval counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state decode, counter update and capture strobes.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + CNT_ONE;
        accept_s = 1'b0;
        cap0_s   = 1'b0;
        cap1_s   = 1'b0;
        cap2_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = SPIN;
                end else begin
                    state_s  = IDLE;
                end
            end
            SPIN: begin
                if (cnt_r == SPIN_LAST) begin
                    cap0_s  = 1'b1;
                    state_s = GAP1;
                    cnt_s   = '0;
                end else begin
                    state_s = SPIN;
                end
            end
            GAP1: begin
                if (cnt_r == GAP_LAST) begin
                    cap1_s  = 1'b1;
                    state_s = GAP2;
                    cnt_s   = '0;
                end else begin
                    state_s = GAP1;
                end
            end
            GAP2: begin
                if (cnt_r == GAP_LAST) begin
                    cap2_s  = 1'b1;
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    state_s = GAP2;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Registered outputs: spin status, reel captures, done pulse and win flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r         <= 1'b0;
            reel0_r        <= '0;
            reel1_r        <= '0;
            reel2_r        <= '0;
            reel_stopped_r <= 3'b000;
            done_r         <= 1'b0;
            win_r          <= 1'b0;
        end else begin
            done_r <= cap2_s;
            if (accept_s) begin
                busy_r         <= 1'b1;
                reel_stopped_r <= 3'b000;
                win_r          <= 1'b0;
            end
            if (cap0_s) begin
                reel0_r           <= sym_s;
                reel_stopped_r[0] <= 1'b1;
            end
            if (cap1_s) begin
                reel1_r           <= sym_s;
                reel_stopped_r[1] <= 1'b1;
            end
            if (cap2_s) begin
                reel2_r           <= sym_s;
                reel_stopped_r[2] <= 1'b1;
                busy_r            <= 1'b0;
                // Compare against the symbol being captured now, not reel2_r.
                win_r             <= (reel0_r == reel1_r) && (reel1_r == sym_s);
            end
        end
    end

    assign bus.lfsr_enable  = (state_r != IDLE);
    assign bus.busy         = busy_r;
    assign bus.reel0        = reel0_r;
    assign bus.reel1        = reel1_r;
    assign bus.reel2        = reel2_r;
    assign bus.reel_stopped = reel_stopped_r;
    assign bus.done         = done_r;
    assign bus.win          = win_r;

endmodule
